fetch_unit: RTL and testbench

//  Instruction-fetch sequencer for the CPU: the reader side of the line memory.
//  - Owns the program counter and drives the memory enable and address.
//  - Captures the returned instruction word into a one-entry output register and

---
 rtl/cpu_pkg.sv | 14 +
 rtl/ip_counter.sv | 33 +++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch path.
//   fetch_state_t : fetch sequencer states
//   IP_W / LINE_W : default instruction-pointer and instruction-word widths
//   HALT_WORD     : sentinel instruction that ends the program
package cpu_pkg;

  localparam int unsigned IP_W   = 8;
  localparam int unsigned LINE_W = 32;

  localparam logic [LINE_W-1:0] HALT_WORD = '1;

  typedef enum logic [1:0] {IDLE, FETCH, HALT} fetch_state_t;

endpackage

// File: rtl/ip_counter.sv
// Program counter register for the fetch unit.
//   clk, n_rst : clock, asynchronous active-low reset (pc <= RESET_IP)
//   load       : load load_ip this cycle (wins over incr)
//   load_ip    : value to load (redirect target or restart address)
//   incr       : advance pc by one, wrapping at all-ones
//   pc         : current program counter
module ip_counter #(
  parameter int unsigned          IP_WIDTH = 8,
  parameter logic [IP_WIDTH-1:0]  RESET_IP = '0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load,
  input  logic [IP_WIDTH-1:0] load_ip,
  input  logic                incr,
  output logic [IP_WIDTH-1:0] pc
);

  logic [IP_WIDTH-1:0] pc_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pc_q <= RESET_IP;
    end else if (load) begin
      pc_q <= load_ip;
    end else if (incr) begin
      pc_q <= pc_q + IP_WIDTH'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: reads line memory at pc, holds one fetched
// instruction for the decoder behind a valid/ready handshake, follows branch
// redirects and stops on the halt sentinel.
//   clk, n_rst      : clock, asynchronous active-low reset
//   start           : pulse; begin fetching at RESET_IP (from IDLE or HALT)
//   mem_en, mem_ip  : line memory read enable / address (mem_ip is always pc)
//   mem_line        : word returned by memory in the same cycle as mem_en
//   inst, inst_ip   : held instruction and the address it came from
//   inst_valid      : inst holds an instruction not yet taken
//   inst_ready      : decoder takes inst this cycle
//   br_valid        : redirect request, br_target is the new pc
//   halted          : sentinel fetched, fetching stopped
// LINE_WIDTH is expected to equal cpu_pkg::LINE_W, the width of HALT_WORD.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned         IP_WIDTH   = IP_W,
  parameter int unsigned         LINE_WIDTH = LINE_W,
  parameter logic [IP_WIDTH-1:0] RESET_IP   = '0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  output logic                  mem_en,
  output logic [IP_WIDTH-1:0]   mem_ip,
  input  logic [LINE_WIDTH-1:0] mem_line,
  output logic [LINE_WIDTH-1:0] inst,
  output logic [IP_WIDTH-1:0]   inst_ip,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  br_valid,
  input  logic [IP_WIDTH-1:0]   br_target,
  output logic                  halted
);

  fetch_state_t          state_q, state_d;
  logic [LINE_WIDTH-1:0] inst_q;
  logic [IP_WIDTH-1:0]   inst_ip_q;
  logic                  inst_valid_q, inst_valid_d;
  logic                  halted_q, halted_d;
  logic                  pc_load, capture, stall, is_halt;
  logic [IP_WIDTH-1:0]   pc_load_ip, pc;

  ip_counter #(
    .IP_WIDTH (IP_WIDTH),
    .RESET_IP (RESET_IP)
  ) u_ip_counter (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (pc_load),
    .load_ip (pc_load_ip),
    .incr    (capture),
    .pc      (pc)
  );

  // A held instruction that is not taken blocks the next fetch; a redirect
  // suppresses the fetch so the wrong-path word is never captured.
  assign stall   = inst_valid_q & ~inst_ready;
  assign mem_en  = (state_q == FETCH) & ~stall & ~br_valid;
  assign mem_ip  = pc;
  assign is_halt = (mem_line == LINE_WIDTH'(HALT_WORD));

  always_comb begin
    state_d      = state_q;
    inst_valid_d = inst_valid_q;
    halted_d     = halted_q;
    pc_load      = 1'b0;
    pc_load_ip   = RESET_IP;
    capture      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_load = 1'b1;
        end
      end
      FETCH: begin
        if (br_valid) begin
          // Held instruction either completes its take or is flushed.
          pc_load      = 1'b1;
          pc_load_ip   = br_target;
          inst_valid_d = 1'b0;
        end else if (mem_en) begin
          if (is_halt) begin
            state_d      = HALT;
            halted_d     = 1'b1;
            inst_valid_d = 1'b0;
          end else begin
            capture      = 1'b1;
            inst_valid_d = 1'b1;
          end
        end
        // mem_en low without a redirect is a stall: everything holds.
      end
      HALT: begin
        if (start) begin
          state_d  = FETCH;
          pc_load  = 1'b1;
          halted_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      inst_q       <= '0;
      inst_ip_q    <= '0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
      if (capture) begin
        inst_q    <= mem_line;
        inst_ip_q <= pc;
      end
    end
  end

  assign inst       = inst_q;
  assign inst_ip    = inst_ip_q;
  assign inst_valid = inst_valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        n_rst, start, inst_ready, br_valid;
  logic        mem_en, inst_valid, halted;
  logic [7:0]  mem_ip, inst_ip, br_target;
  logic [31:0] mem_line, inst;

  logic [31:0] mem [256];
  logic [39:0] sb [$];
  int          checks = 0;
  int          errors = 0;
  int          takes  = 0;
  int          t0;

  always #5 clk = ~clk;

  assign mem_line = mem[mem_ip];

  fetch_unit #(
    .IP_WIDTH   (8),
    .LINE_WIDTH (32),
    .RESET_IP   (8'd0)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .mem_en     (mem_en),
    .mem_ip     (mem_ip),
    .mem_line   (mem_line),
    .inst       (inst),
    .inst_ip    (inst_ip),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .halted     (halted)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int a);
    sb.push_back({mem[a], 8'(a)});
  endtask

  // Settle inputs, score a transfer about to happen, then advance one clock
  // and return just after the following falling edge.
  task automatic cyc();
    logic [39:0] e;
    #1;
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      takes++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(inst_ip), 64'hdead);
      end else begin
        e = sb.pop_front();
        chk("sb_inst", 64'(inst), 64'(e[39:8]));
        chk("sb_ip", 64'(inst_ip), 64'(e[7:0]));
      end
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; inst_ready = 1'b1; br_valid = 1'b0; br_target = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1234_0000 + 32'(i);
    mem[3] = 32'hffff_ffff;

    // Reset values
    #1;
    chk("rst_valid", 64'(inst_valid), 0);
    chk("rst_inst", 64'(inst), 0);
    chk("rst_ip", 64'(inst_ip), 0);
    chk("rst_halted", 64'(halted), 0);
    chk("rst_mem_en", 64'(mem_en), 0);
    chk("rst_mem_ip", 64'(mem_ip), 0);
    @(negedge clk); #1;
    n_rst = 1'b1;
    cyc(); cyc();
    chk("idle_no_fetch", 64'(mem_en), 0);

    // 1: straight-line run to the sentinel
    push(0); push(1); push(2);
    start = 1'b1; cyc(); start = 1'b0;
    chk("t1_first_not_yet", 64'(inst_valid), 0);
    chk("t1_mem_en", 64'(mem_en), 1);
    cyc();
    chk("t1_valid_c2", 64'(inst_valid), 1);
    chk("t1_ip0", 64'(inst_ip), 0);
    cyc(); chk("t1_ip1", 64'(inst_ip), 1);
    cyc(); chk("t1_ip2", 64'(inst_ip), 2);
    cyc();
    chk("t1_halted", 64'(halted), 1);
    chk("t1_no_sentinel", 64'(inst_valid), 0);
    chk("t1_mem_en_off", 64'(mem_en), 0);
    chk("t1_pc_hold", 64'(mem_ip), 3);
    cyc();
    chk("t1_mem_en_stays", 64'(mem_en), 0);
    chk("t1_drained", 64'(sb.size()), 0);
    chk("t1_takes", 64'(takes), 3);

    // 2: restart from HALT, stall on B for three cycles
    push(0); push(1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("t2_halt_clear", 64'(halted), 0);
    cyc(); cyc();
    chk("t2_b_ip", 64'(inst_ip), 1);
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t2_stall_inst", 64'(inst), 64'(mem[1]));
      chk("t2_stall_ip", 64'(inst_ip), 1);
      chk("t2_stall_valid", 64'(inst_valid), 1);
      chk("t2_stall_mem_en", 64'(mem_en), 0);
      chk("t2_stall_pc", 64'(mem_ip), 2);
    end
    inst_ready = 1'b1;
    cyc();
    chk("t2_resume_c", 64'(inst), 64'(mem[2]));
    chk("t2_resume_ip", 64'(inst_ip), 2);

    // 3: redirect flushes an untaken instruction
    inst_ready = 1'b0; br_valid = 1'b1; br_target = 8'd8;
    cyc();
    br_valid = 1'b0;
    chk("t3_flushed", 64'(inst_valid), 0);
    chk("t3_pc_target", 64'(mem_ip), 8);
    push(8);
    inst_ready = 1'b1;
    cyc();
    chk("t3_valid", 64'(inst_valid), 1);
    chk("t3_ip", 64'(inst_ip), 8);

    // 4: redirect together with a take
    push(9);
    cyc();
    chk("t4_ip9", 64'(inst_ip), 9);
    t0 = takes;
    br_valid = 1'b1; br_target = 8'd20;
    cyc();
    br_valid = 1'b0;
    chk("t4_take_once", 64'(takes - t0), 1);
    chk("t4_valid_off", 64'(inst_valid), 0);
    chk("t4_pc_target", 64'(mem_ip), 20);
    push(20);
    cyc();
    chk("t4_ip_target", 64'(inst_ip), 20);

    // 5: pc wraps from all-ones
    br_valid = 1'b1; br_target = 8'hff;
    cyc();
    br_valid = 1'b0;
    push(255); push(0);
    cyc();
    chk("t5_ip_max", 64'(inst_ip), 255);
    chk("t5_wrap_pc", 64'(mem_ip), 0);
    cyc();
    chk("t5_wrap_ip", 64'(inst_ip), 0);
    chk("t5_wrap_inst", 64'(inst), 64'(mem[0]));

    // 6: asynchronous reset while holding an instruction
    inst_ready = 1'b0;
    cyc();
    chk("t6_held", 64'(inst_valid), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("t6_valid", 64'(inst_valid), 0);
    chk("t6_inst", 64'(inst), 0);
    chk("t6_ip", 64'(inst_ip), 0);
    chk("t6_halted", 64'(halted), 0);
    chk("t6_mem_en", 64'(mem_en), 0);
    chk("t6_mem_ip", 64'(mem_ip), 0);
    sb.delete();
    @(negedge clk); #1;
    n_rst = 1'b1; inst_ready = 1'b1;
    cyc(); cyc();
    chk("t6_no_fetch", 64'(mem_en), 0);
    chk("t6_still_idle", 64'(inst_valid), 0);

    // Run to HALT again, then restart refetches from RESET_IP
    push(0); push(1); push(2);
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    chk("t6_halted_again", 64'(halted), 1);
    push(0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("t6_restart_clear", 64'(halted), 0);
    chk("t6_restart_pc", 64'(mem_ip), 0);
    chk("t6_restart_en", 64'(mem_en), 1);
    cyc();
    chk("t6_refetch_ip", 64'(inst_ip), 0);
    chk("t6_refetch_valid", 64'(inst_valid), 1);
    cyc();
    chk("t6_drained", 64'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
